page_out_arbiter: RTL and testbench
===================================

# page_out_arbiter

Round-robin arbiter that shares the single user-to-interface output port of a page's leaf interface between up to NUM_REQ user-kernel output streams. It sits between the user kernel(s) and the leaf interface's `din_leaf_user2interface` / `vld_user2interface` / `ack_interface2user` port. It holds a grant for a bounded burst so consecutive words from one source stay contiguous. It drives a registered output stage, so the leaf interface never sees combinational paths back to the kernels.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting streams (2..8)
- REQ_BITS, 2, width of grant index, ceil(log2(NUM_REQ))
- PAYLOAD_BITS, 32, data word width
- BURST_LEN, 16, maximum words transferred per grant (1..255)

Ports:
- clk  in  1  single clock for the page
- reset  in  1  synchronous, active-low reset (0 = reset asserted)
- req_din  in  NUM_REQ*PAYLOAD_BITS  requester data; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- req_vld  in  NUM_REQ  requester i has a valid word
- req_ack  out  NUM_REQ  word from requester i accepted this cycle
- dout  out  PAYLOAD_BITS  word to leaf interface
- vld_out  out  1  dout valid
- ack_in  in  1  leaf interface accepts dout this cycle
- grant_id  out  REQ_BITS  index of current grant holder (valid when busy=1)
- busy  out  1  a grant is currently held

## Operation
- Transfer rule, both sides: a word moves on a cycle where vld and ack are both 1. The requester keeps vld and data stable until acked.
- Output stage: one-entry register (out_vld, out_data). out_ready = !out_vld | ack_in.
- FSM states: IDLE, GRANT.
- IDLE: if any req_vld, select the first asserted index at or after rr_ptr, wrapping modulo NUM_REQ. Load grant_id, clear burst_cnt, go to GRANT. No word is accepted in the IDLE cycle.
- GRANT: req_ack[grant_id] = req_vld[grant_id] & out_ready. All other req_ack bits are 0. On accept, out_data <= req word, out_vld <= 1, burst_cnt++.
- If ack_in with no accept, out_vld <= 0.
- Release grant, return to IDLE, and set rr_ptr <= grant_id+1 (wrap) when either:
  - the accepted word makes burst_cnt == BURST_LEN, or
  - req_vld[grant_id] == 0 in GRANT.
- The output register may still hold the last word after release; it drains independently.
- req_ack is a combinational function of registered grant state, req_vld and the out_ready term (ack_in, out_vld). There is no combinational path from req_din to any output other than through the register.
- burst_cnt width is 8 bits. It never exceeds BURST_LEN.

## Timing
- Reset (reset==0 at a clk edge): state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, out_vld=0, out_data=0, busy=0, req_ack=0. Reset mid-burst discards the held output word. The leaf interface sees vld_out=0 the cycle after the reset edge.
- Arbitration latency: req_vld rising in IDLE gives the first req_ack 1 cycle later, and vld_out 2 cycles after req_vld.
- Steady-state throughput with ack_in held 1 is one word per cycle within a burst.
- Each grant switch costs 1 bubble cycle, spent in IDLE.
- Backpressure: if ack_in=0 with out_vld=1, req_ack=0 and the grant is held. burst_cnt does not advance.
- Simultaneous events:
  - ack_in and a new accept in the same cycle: the register is replaced, out_vld stays 1.
  - The last burst word accepted while other requesters are pending: IDLE next cycle, then the next index after grant_id wins.
- Only one requester active: it is re-granted after each burst, with a 1-cycle bubble every BURST_LEN words.
- busy = (state==GRANT). grant_id holds its value in IDLE until the next grant.

## Test plan
- Reset: hold reset=0 for 3 cycles with all req_vld=1 and ack_in=1 -> vld_out=0, req_ack=0000, busy=0 throughout. After release, req_ack[0] first asserts on the 2nd cycle.
- Round-robin, NUM_REQ=4, BURST_LEN=4: all four requesters send 8 words (0xA0000000+n, 0xB…, 0xC…, 0xD…), ack_in=1 -> dout order is A0-3, B0-3, C0-3, D0-3, A4-7, … with exactly one vld_out=0 bubble between bursts. Total 32 words, no loss or duplication.
- Early release: requester 2 sends 2 words then drops vld while requesters 1 and 3 are pending (rr_ptr=2) -> grant goes to 3, then 1. busy drops for exactly 1 cycle between grants.
- Backpressure: ack_in toggles 1,0,0,1 repeating during a 16-word burst from requester 1 -> dout sequence is identical to the input. req_ack[1]=0 whenever out_vld=1 and ack_in=0. burst_cnt ends at 16 and the grant releases.
- Reset mid-burst: assert reset=0 after the 5th word of a burst -> next cycle vld_out=0. After release, arbitration restarts at requester 0 regardless of the previous rr_ptr.
- Single requester, BURST_LEN=1: requester 3 streams 10 words -> vld_out pattern is 1,0 repeating (a bubble after every word). grant_id=3 on every grant.

Source files
------------

// File: rtl/page_out_arbiter.sv
// page_out_arbiter
//
// Round-robin arbiter that shares the single user-to-interface output port of
// a page's leaf interface between up to NUM_REQ user-kernel output streams.
// A grant is held for at most BURST_LEN accepted words so that consecutive
// words from one source stay contiguous. The word handed to the leaf
// interface comes from a one-entry output register, so the leaf interface
// never sees a combinational path back to the kernels.
//
// Ports:
//   clk       in   page clock
//   reset     in   synchronous reset, active low (0 = reset asserted)
//   req_din   in   requester words, requester i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   req_vld   in   requester i has a valid word
//   req_ack   out  word from requester i accepted this cycle
//   dout      out  word to the leaf interface
//   vld_out   out  dout valid
//   ack_in    in   leaf interface accepts dout this cycle
//   grant_id  out  index of the current grant holder (meaningful when busy=1)
//   busy      out  a grant is currently held

module page_out_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_BITS     = 2,
  parameter int PAYLOAD_BITS = 32,
  parameter int BURST_LEN    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_din,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [PAYLOAD_BITS-1:0]         dout,
  output logic                            vld_out,
  input  logic                            ack_in,
  output logic [REQ_BITS-1:0]             grant_id,
  output logic                            busy
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t                    state, state_nxt;
  logic [REQ_BITS-1:0]       rr_ptr, rr_ptr_nxt;
  logic [REQ_BITS-1:0]       grant_nxt;
  logic [7:0]                burst_cnt, burst_cnt_nxt;
  logic                      out_vld;
  logic [PAYLOAD_BITS-1:0]   out_data;
  logic                      out_ready;
  logic                      accept;
  logic                      found;
  logic [REQ_BITS-1:0]       pick;
  logic [REQ_BITS-1:0]       grant_inc;
  logic [PAYLOAD_BITS-1:0]   grant_word;

  // The output register can take a new word when it is empty or is being
  // drained this same cycle.
  assign out_ready  = !out_vld || ack_in;
  assign accept     = (state == GRANT) && req_vld[grant_id] && out_ready;
  assign grant_word = req_din[int'(grant_id)*PAYLOAD_BITS +: PAYLOAD_BITS];

  // grant_id + 1, wrapping at NUM_REQ (which need not be a power of two).
  assign grant_inc = (grant_id == REQ_BITS'(NUM_REQ - 1)) ? '0 : grant_id + REQ_BITS'(1);

  // Round-robin search: first asserted req_vld at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = rr_ptr;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        pick  = REQ_BITS'(idx);
      end
    end
  end

  // Next-state and handshake logic. A grant is released either when the
  // holder stops presenting data or when the accepted word completes the
  // burst; in both cases the pointer moves past the holder for fairness.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_id;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    req_ack       = '0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt     = pick;
          burst_cnt_nxt = 8'd0;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        req_ack[grant_id] = req_vld[grant_id] && out_ready;
        if (!req_vld[grant_id]) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = grant_inc;
        end else if (accept) begin
          burst_cnt_nxt = burst_cnt + 8'd1;
          if (burst_cnt == 8'(BURST_LEN - 1)) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = grant_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state plus the output register. The output register drains
  // independently of the grant, so it may still hold a word after release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= 8'd0;
      out_vld   <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_id  <= grant_nxt;
      burst_cnt <= burst_cnt_nxt;
      if (accept) begin
        out_data <= grant_word;
        out_vld  <= 1'b1;
      end else if (ack_in) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign dout    = out_data;
  assign vld_out = out_vld;
  assign busy    = (state == GRANT);

endmodule

// File: tb/tb_page_out_arbiter.sv
// tb_page_out_arbiter
//
// Directed bench for page_out_arbiter. Three copies of the arbiter share the
// same stimulus (BURST_LEN = 4, 16 and 1); sel chooses which copy's outputs
// the requester and leaf-interface models respond to. Requesters are simple
// word lists that advance on vld&ack; the leaf interface collects every word
// seen with vld_out&ack_in.

module tb_page_out_arbiter;

  localparam int NR = 4;
  localparam int PB = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NR*PB-1:0]  req_din;
  logic [NR-1:0]     req_vld;
  logic              ack_in;

  logic [NR-1:0] ack_a, ack_b, ack_c;
  logic [PB-1:0] dout_a, dout_b, dout_c;
  logic          vld_a, vld_b, vld_c;
  logic [1:0]    gid_a, gid_b, gid_c;
  logic          busy_a, busy_b, busy_c;

  page_out_arbiter #(.NUM_REQ(NR), .REQ_BITS(2), .PAYLOAD_BITS(PB), .BURST_LEN(4)) u_dut_bl4 (
    .clk(clk), .reset(reset), .req_din(req_din), .req_vld(req_vld), .req_ack(ack_a),
    .dout(dout_a), .vld_out(vld_a), .ack_in(ack_in), .grant_id(gid_a), .busy(busy_a));

  page_out_arbiter #(.NUM_REQ(NR), .REQ_BITS(2), .PAYLOAD_BITS(PB), .BURST_LEN(16)) u_dut_bl16 (
    .clk(clk), .reset(reset), .req_din(req_din), .req_vld(req_vld), .req_ack(ack_b),
    .dout(dout_b), .vld_out(vld_b), .ack_in(ack_in), .grant_id(gid_b), .busy(busy_b));

  page_out_arbiter #(.NUM_REQ(NR), .REQ_BITS(2), .PAYLOAD_BITS(PB), .BURST_LEN(1)) u_dut_bl1 (
    .clk(clk), .reset(reset), .req_din(req_din), .req_vld(req_vld), .req_ack(ack_c),
    .dout(dout_c), .vld_out(vld_c), .ack_in(ack_in), .grant_id(gid_c), .busy(busy_c));

  logic [31:0] src_mem [NR][64];
  int          src_cnt [NR];
  int          src_idx [NR];
  int          sel;
  int          ack_mode;
  int          cyc;
  int          chk_cnt;
  int          pass_cnt;

  logic [NR-1:0] s_ack, s_reqvld;
  logic [PB-1:0] s_dout;
  logic          s_vld, s_busy, s_ackin, s_reset;
  logic [1:0]    s_gid;

  logic [31:0] got [64];
  int          got_n;

  // Present each requester's next word; ack_mode 1 gives the 1,0,0,1 pattern.
  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      if (src_idx[i] < src_cnt[i]) begin
        req_vld[i]           = 1'b1;
        req_din[i*PB +: PB]  = src_mem[i][src_idx[i]];
      end else begin
        req_vld[i]           = 1'b0;
        req_din[i*PB +: PB]  = '0;
      end
    end
    if (ack_mode == 0) ack_in = 1'b1;
    else               ack_in = ((cyc % 4) == 0) || ((cyc % 4) == 3);
  endtask

  // One clock: sample on the falling edge, then update the models after the
  // rising edge using what was sampled.
  task automatic tick();
    @(negedge clk);
    s_reset  = reset;
    s_reqvld = req_vld;
    s_ackin  = ack_in;
    case (sel)
      0: begin s_ack = ack_a; s_dout = dout_a; s_vld = vld_a; s_gid = gid_a; s_busy = busy_a; end
      1: begin s_ack = ack_b; s_dout = dout_b; s_vld = vld_b; s_gid = gid_b; s_busy = busy_b; end
      default: begin s_ack = ack_c; s_dout = dout_c; s_vld = vld_c; s_gid = gid_c; s_busy = busy_c; end
    endcase
    if (s_reset && s_vld && s_ackin && got_n < 64) begin
      got[got_n] = s_dout;
      got_n++;
    end
    @(posedge clk);
    #1;
    if (s_reset) begin
      for (int i = 0; i < NR; i++)
        if (s_reqvld[i] && s_ack[i]) src_idx[i]++;
    end
    cyc++;
    drive_inputs();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NR; i++) begin
      src_cnt[i] = 0;
      src_idx[i] = 0;
    end
    got_n = 0;
  endtask

  task automatic load(input int i, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      if (src_cnt[i] < 64) begin
        src_mem[i][src_cnt[i]] = base + 32'(k);
        src_cnt[i]++;
      end
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    ack_mode = 0;
    clear_sources();
    drive_inputs();
    repeat (2) tick();
    reset = 1'b1;
    drive_inputs();
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    ack_mode = 0;
    sel      = 0;
    clear_sources();
    for (int i = 0; i < NR; i++) load(i, 32'h0100_0000 * 32'(i + 1), 4);
    drive_inputs();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_cnt++;
      if (s_vld !== 1'b0) $display("[TB] FAIL reset_vld_out cyc%0d got=%b exp=0", c, s_vld);
      else pass_cnt++;
      chk_cnt++;
      if (s_ack !== 4'b0000) $display("[TB] FAIL reset_req_ack cyc%0d got=%b exp=0000", c, s_ack);
      else pass_cnt++;
      chk_cnt++;
      if (s_busy !== 1'b0) $display("[TB] FAIL reset_busy cyc%0d got=%b exp=0", c, s_busy);
      else pass_cnt++;
    end
    reset = 1'b1;
    drive_inputs();
    tick();
    chk_cnt++;
    if (s_ack !== 4'b0000) $display("[TB] FAIL release_ack_cycle1 got=%b exp=0000", s_ack);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (s_ack !== 4'b0001) $display("[TB] FAIL release_ack_cycle2 got=%b exp=0001", s_ack);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int k;
    logic [31:0] exp;
    sel = 0;
    do_reset();
    for (int i = 0; i < NR; i++) load(i, 32'hA000_0000 + 32'h1000_0000 * 32'(i), 8);
    drive_inputs();
    k = -1;
    repeat (60) begin
      tick();
      if (k < 0 && s_vld) k = 0;
      if (k >= 0 && k < 39) begin
        chk_cnt++;
        if (s_vld !== ((k % 5) != 4))
          $display("[TB] FAIL rr_bubble k=%0d got=%b exp=%b", k, s_vld, ((k % 5) != 4));
        else pass_cnt++;
      end
      if (k >= 0) k++;
    end
    chk_cnt++;
    if (got_n != 32) $display("[TB] FAIL rr_word_count got=%0d exp=32", got_n);
    else pass_cnt++;
    for (int w = 0; w < got_n && w < 32; w++) begin
      exp = 32'hA000_0000 + 32'h1000_0000 * 32'((w % 16) / 4) + 32'((w / 16) * 4 + (w % 4));
      chk_cnt++;
      if (got[w] !== exp) $display("[TB] FAIL rr_word[%0d] got=%h exp=%h", w, got[w], exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_early_release();
    int gcount, gap;
    logic prev_busy;
    logic [1:0] gseq [3];
    logic [31:0] exp [6];
    sel = 0;
    do_reset();
    load(1, 32'h1111_0000, 1);
    drive_inputs();
    repeat (8) tick();
    got_n = 0;
    load(1, 32'h1111_0100, 2);
    load(2, 32'h2222_0000, 2);
    load(3, 32'h3333_0000, 2);
    drive_inputs();
    gcount    = 0;
    gap       = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 3; i++) gseq[i] = 2'd0;
    repeat (30) begin
      tick();
      if (!s_busy) gap++;
      if (s_busy && !prev_busy) begin
        if (gcount < 3) gseq[gcount] = s_gid;
        if (gcount > 0) begin
          chk_cnt++;
          if (gap != 1) $display("[TB] FAIL early_gap%0d got=%0d exp=1", gcount, gap);
          else pass_cnt++;
        end
        gcount++;
        gap = 0;
      end
      prev_busy = s_busy;
    end
    chk_cnt++;
    if (gcount != 3) $display("[TB] FAIL early_grant_count got=%0d exp=3", gcount);
    else pass_cnt++;
    chk_cnt++;
    if (gseq[0] !== 2'd2 || gseq[1] !== 2'd3 || gseq[2] !== 2'd1)
      $display("[TB] FAIL early_grant_order got=%0d,%0d,%0d exp=2,3,1", gseq[0], gseq[1], gseq[2]);
    else pass_cnt++;
    exp = '{32'h2222_0000, 32'h2222_0001, 32'h3333_0000, 32'h3333_0001, 32'h1111_0100, 32'h1111_0101};
    chk_cnt++;
    if (got_n != 6) $display("[TB] FAIL early_word_count got=%0d exp=6", got_n);
    else pass_cnt++;
    for (int w = 0; w < got_n && w < 6; w++) begin
      chk_cnt++;
      if (got[w] !== exp[w]) $display("[TB] FAIL early_word[%0d] got=%h exp=%h", w, got[w], exp[w]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic released, prev_busy;
    sel = 1;
    do_reset();
    ack_mode = 1;
    load(1, 32'h5000_0000, 17);
    drive_inputs();
    acc       = 0;
    released  = 1'b0;
    prev_busy = 1'b0;
    repeat (80) begin
      tick();
      if (s_vld && !s_ackin) begin
        chk_cnt++;
        if (s_ack[1] !== 1'b0) $display("[TB] FAIL bp_hold cyc=%0d got=%b exp=0", cyc, s_ack[1]);
        else pass_cnt++;
      end
      if (!released && s_ack[1] && s_reqvld[1]) acc++;
      if (!released && prev_busy && !s_busy) begin
        released = 1'b1;
        chk_cnt++;
        if (acc != 16) $display("[TB] FAIL bp_burst_len got=%0d exp=16", acc);
        else pass_cnt++;
      end
      prev_busy = s_busy;
    end
    chk_cnt++;
    if (!released) $display("[TB] FAIL bp_release got=0 exp=1");
    else pass_cnt++;
    chk_cnt++;
    if (got_n != 17) $display("[TB] FAIL bp_word_count got=%0d exp=17", got_n);
    else pass_cnt++;
    for (int w = 0; w < got_n && w < 17; w++) begin
      chk_cnt++;
      if (got[w] !== 32'h5000_0000 + 32'(w))
        $display("[TB] FAIL bp_word[%0d] got=%h exp=%h", w, got[w], 32'h5000_0000 + 32'(w));
      else pass_cnt++;
    end
    ack_mode = 0;
  endtask

  task automatic test_reset_mid_burst();
    int acc, guard;
    logic seen;
    sel = 1;
    do_reset();
    load(2, 32'h7000_0000, 1);
    drive_inputs();
    repeat (8) tick();
    load(1, 32'h6000_0000, 10);
    drive_inputs();
    acc   = 0;
    guard = 0;
    while (acc < 5 && guard < 40) begin
      tick();
      guard++;
      if (s_reset && s_ack[1] && s_reqvld[1]) acc++;
    end
    chk_cnt++;
    if (acc != 5) $display("[TB] FAIL mid_accepts got=%0d exp=5", acc);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    chk_cnt++;
    if (s_vld !== 1'b1 || s_dout !== 32'h6000_0004)
      $display("[TB] FAIL mid_last_word got=%b/%h exp=1/60000004", s_vld, s_dout);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (s_vld !== 1'b0) $display("[TB] FAIL mid_vld_after_reset got=%b exp=0", s_vld);
    else pass_cnt++;
    chk_cnt++;
    if (s_busy !== 1'b0 || s_ack !== 4'b0000)
      $display("[TB] FAIL mid_state_after_reset got=busy%b/ack%b exp=busy0/ack0000", s_busy, s_ack);
    else pass_cnt++;
    load(0, 32'h8000_0000, 1);
    load(3, 32'h9000_0000, 1);
    reset = 1'b1;
    drive_inputs();
    seen  = 1'b0;
    guard = 0;
    while (!seen && guard < 10) begin
      tick();
      guard++;
      if (s_busy) seen = 1'b1;
    end
    chk_cnt++;
    if (!seen || s_gid !== 2'd0)
      $display("[TB] FAIL mid_restart_grant got=seen%b/id%0d exp=seen1/id0", seen, s_gid);
    else pass_cnt++;
  endtask

  task automatic test_single_burst1();
    int k;
    sel = 2;
    do_reset();
    load(3, 32'hC0DE_0000, 10);
    drive_inputs();
    k = -1;
    repeat (40) begin
      tick();
      if (k < 0 && s_vld) k = 0;
      if (k >= 0 && k < 19) begin
        chk_cnt++;
        if (s_vld !== ((k % 2) == 0))
          $display("[TB] FAIL bl1_pattern k=%0d got=%b exp=%b", k, s_vld, ((k % 2) == 0));
        else pass_cnt++;
      end
      if (k >= 0) k++;
      if (s_busy) begin
        chk_cnt++;
        if (s_gid !== 2'd3) $display("[TB] FAIL bl1_grant_id got=%0d exp=3", s_gid);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (got_n != 10) $display("[TB] FAIL bl1_word_count got=%0d exp=10", got_n);
    else pass_cnt++;
    for (int w = 0; w < got_n && w < 10; w++) begin
      chk_cnt++;
      if (got[w] !== 32'hC0DE_0000 + 32'(w))
        $display("[TB] FAIL bl1_word[%0d] got=%h exp=%h", w, got[w], 32'hC0DE_0000 + 32'(w));
      else pass_cnt++;
    end
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    cyc      = 0;
    sel      = 0;
    ack_mode = 0;
    reset    = 1'b0;
    req_vld  = '0;
    req_din  = '0;
    ack_in   = 1'b1;
    test_reset();
    test_round_robin();
    test_early_release();
    test_backpressure();
    test_reset_mid_burst();
    test_single_burst1();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
